// File: rtl/mcp_bus_receiver.sv
// mcp_bus_receiver: toggle req/ack multi-cycle-path bus receiver; CLK/RST in, UnsyncBus+ReqToggle from source, SyncBus/SyncValid/SyncReady to consumer, AckToggle back to source, sticky Overrun
module mcp_bus_receiver #(
  parameter int BusWidth  = 8,
  parameter int NumStages = 2
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [BusWidth-1:0] UnsyncBus,
  input  logic                ReqToggle,
  output logic [BusWidth-1:0] SyncBus,
  output logic                SyncValid,
  input  logic                SyncReady,
  output logic                AckToggle,
  output logic                Overrun
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t                state_q;
  logic [NumStages-1:0]  sync_q;
  logic                  prev_q;
  logic [BusWidth-1:0]   bus_q;
  logic                  valid_q;
  logic                  ack_q;
  logic                  ovr_q;
  logic                  req_pulse;
  assign req_pulse = sync_q[NumStages-1] ^ prev_q;
  assign SyncBus   = bus_q;
  assign SyncValid = valid_q;
  assign AckToggle = ack_q;
  assign Overrun   = ovr_q;
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      state_q <= IDLE;
      bus_q   <= '0;
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[NumStages-2:0], ReqToggle};
      prev_q <= sync_q[NumStages-1];
      if (state_q == IDLE) begin
        if (req_pulse) begin
          bus_q   <= UnsyncBus;
          valid_q <= 1'b1;
          state_q <= HOLD;
        end
      end else begin
        if (req_pulse) ovr_q <= 1'b1;
        if (SyncReady) begin
          valid_q <= 1'b0;
          ack_q   <= ~ack_q;
          state_q <= IDLE;
        end
      end
    end
  end
endmodule
